// File: rtl/lpif_slave_link_sync.sv
// LPIF slave link bring-up sequencer with a downstream beat FIFO and credit return.
// Optional macro LPIF_SLAVE_STROBE_GEN_EN selects the periodic auto-strobe generator.
module lpif_slave_link_sync #(
  parameter int unsigned DATA_WIDTH = 154,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                  clk_wr,
  input  logic                  rst_wr_n,
  input  logic                  tx_online,
  input  logic                  rx_online,
  input  logic [15:0]           delay_x_value,
  input  logic [15:0]           delay_y_value,
  input  logic [15:0]           delay_z_value,
  input  logic                  tx_stb_userbit,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_push,
  output logic [DATA_WIDTH-1:0] dstrm_data,
  output logic                  dstrm_valid,
  input  logic                  dstrm_ready,
  output logic                  tx_online_delay,
  output logic                  rx_online_delay,
  output logic                  tx_auto_stb_userbit,
  output logic                  credit_return,
  output logic [31:0]           debug_status
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_TX_WAIT = 2'd1;
  localparam logic [1:0] ST_RX_WAIT = 2'd2;
  localparam logic [1:0] ST_ONLINE  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        rx_arm_q, rx_arm_d;
  logic        txd_q, txd_d;
  logic        rxd_q, rxd_d;
  logic        flush;

  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  credit_q;
  logic                  push_req, push, pop, full;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  // rx_arm_q marks that the RX delay count is running; rx_online low clears it so the wait restarts.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rx_arm_d = rx_arm_q;
    txd_d    = txd_q;
    rxd_d    = rxd_q;
    flush    = 1'b0;
    if (!tx_online) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      rx_arm_d = 1'b0;
      txd_d    = 1'b0;
      rxd_d    = 1'b0;
      flush    = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_TX_WAIT;
          cnt_d   = delay_x_value;
        end
        ST_TX_WAIT: begin
          if (cnt_q == '0) begin
            state_d  = ST_RX_WAIT;
            txd_d    = 1'b1;
            rx_arm_d = 1'b0;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        ST_RX_WAIT: begin
          if (!rx_online) begin
            rx_arm_d = 1'b0;
          end else if (!rx_arm_q) begin
            rx_arm_d = 1'b1;
            cnt_d    = delay_y_value;
          end else if (cnt_q == '0) begin
            state_d  = ST_ONLINE;
            rxd_d    = 1'b1;
            rx_arm_d = 1'b0;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        ST_ONLINE: begin
          if (!rx_online) begin
            state_d = ST_RX_WAIT;
            rxd_d   = 1'b0;
            flush   = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // A flush cancels any pop in the same cycle, so discarded entries never return credit.
  always_comb begin
    full     = (count_q == CW'(FIFO_DEPTH));
    push_req = rx_push & rxd_q;
    pop      = (count_q != '0) & dstrm_ready & ~flush;
    push     = push_req & (~full | pop) & ~flush;
    ovf_d    = ovf_q | (push_req & full & ~pop & ~flush);
    count_d  = count_q;
    if (flush) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rx_arm_q <= 1'b0;
      txd_q    <= 1'b0;
      rxd_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      credit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rx_arm_q <= rx_arm_d;
      txd_q    <= txd_d;
      rxd_q    <= rxd_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      credit_q <= pop;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk_wr) begin
    if (push) mem_q[wr_ptr_q] <= rx_data;
  end

  assign dstrm_valid     = (count_q != '0);
  assign dstrm_data      = dstrm_valid ? mem_q[rd_ptr_q] : '0;
  assign tx_online_delay = txd_q;
  assign rx_online_delay = rxd_q;
  assign credit_return   = credit_q;
  assign debug_status    = {12'h0, txd_q, rxd_q, ovf_q, state_q, 7'h0, 8'(count_q)};

`ifdef LPIF_SLAVE_STROBE_GEN_EN
  logic [15:0] stb_cnt_q;

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      stb_cnt_q <= '0;
    end else if (!txd_q || stb_cnt_q >= delay_z_value) begin
      stb_cnt_q <= '0;
    end else begin
      stb_cnt_q <= stb_cnt_q + 16'd1;
    end
  end

  assign tx_auto_stb_userbit = txd_q & (stb_cnt_q == '0);
`else
  logic unused_delay_z;
  assign unused_delay_z      = ^delay_z_value;
  assign tx_auto_stb_userbit = tx_stb_userbit & txd_q;
`endif

endmodule
